ro_sched_n: RTL and testbench

- Parametrised, fully synchronous successor to the per-core gray-slot readout blocks.
- Owns the master gray counter. Decodes the single toggling gray bit per clk_master cycle into a readout slot for one of N_CH cores.
- In that slot, samples the core's DATA_W event bits (eve, pol_eve, ...) onto one shared registered readout bus, replacing per-core tristate buffers.
- Adds a per-channel mask, a sticky event-accumulate mode for short event pulses, a channel-ID tag and a frame marker.

---
 rtl/ro_sched_n.sv | 90 +++++++++
 tb/tb_ro_sched_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ro_sched_n.sv
// rtl/ro_sched_n.sv - gray-count slot scheduler driving one shared registered readout bus
module ro_sched_n #(
  parameter int N_CH       = 8,
  parameter int DATA_W     = 2,
  parameter int CNT_W      = 19,
  parameter int BIT_OFFSET = 0,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_master,
  input  logic                     rstb,
  input  logic                     en,
  input  logic                     latch_mode,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [CNT_W-1:0]         gray_count,
  output logic                     ro_valid,
  output logic [CH_W-1:0]          ro_ch,
  output logic [DATA_W-1:0]        ro_data,
  output logic                     ro_frame
);

  localparam int KW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]  bin;
  logic [CNT_W-1:0]  bin_inc;
  logic [KW-1:0]     k;
  logic              found;
  logic [N_CH-1:0]   svc;
  logic              svc_any;
  logic [CH_W-1:0]   svc_ch;
  logic [DATA_W-1:0] svc_data;
  logic [DATA_W-1:0] acc     [N_CH];
  logic [DATA_W-1:0] acc_nxt [N_CH];

  assign bin_inc = bin + CNT_W'(1);

  // Index of the gray bit about to toggle = trailing ones of bin; MSB on wrap.
  always_comb begin
    k     = KW'(CNT_W - 1);
    found = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (!found && !bin[i]) begin
        k     = KW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    svc      = '0;
    svc_any  = 1'b0;
    svc_ch   = '0;
    svc_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      svc[c] = en && ch_mask[c] && (int'(k) == c + BIT_OFFSET);
      // Serviced data leaves through the output word, so the accumulator restarts empty.
      acc_nxt[c] = (latch_mode && ch_mask[c] && !svc[c]) ?
                   (acc[c] | ch_data[c*DATA_W +: DATA_W]) : '0;
      if (svc[c]) begin
        svc_any  = 1'b1;
        svc_ch   = CH_W'(c);
        svc_data = latch_mode ? (acc[c] | ch_data[c*DATA_W +: DATA_W])
                              : ch_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      bin        <= '0;
      gray_count <= '0;
      ro_valid   <= 1'b0;
      ro_ch      <= '0;
      ro_data    <= '0;
      ro_frame   <= 1'b0;
      for (int c = 0; c < N_CH; c++) acc[c] <= '0;
    end else begin
      if (en) begin
        bin        <= bin_inc;
        gray_count <= bin_inc ^ (bin_inc >> 1);
      end
      ro_frame <= en && (&bin);
      ro_valid <= svc_any;
      ro_ch    <= svc_ch;
      ro_data  <= svc_data;
      for (int c = 0; c < N_CH; c++) acc[c] <= acc_nxt[c];
    end
  end

endmodule

// File: tb/tb_ro_sched_n.sv
// tb/tb_ro_sched_n.sv - directed self-checking bench for ro_sched_n (N_CH=4, CNT_W=6)
module tb_ro_sched_n;

  localparam int N_CH = 4, DATA_W = 2, CNT_W = 6, BIT_OFFSET = 0, CH_W = 2;

  logic              clk_master = 1'b0;
  logic              rstb, en, latch_mode;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [CNT_W-1:0]  gray_count;
  logic              ro_valid;
  logic [CH_W-1:0]   ro_ch;
  logic [DATA_W-1:0] ro_data;
  logic              ro_frame;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0] exp_seq [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3};

  ro_sched_n #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
               .BIT_OFFSET(BIT_OFFSET), .CH_W(CH_W)) dut (
    .clk_master(clk_master), .rstb(rstb), .en(en), .latch_mode(latch_mode),
    .ch_mask(ch_mask), .ch_data(ch_data), .gray_count(gray_count),
    .ro_valid(ro_valid), .ro_ch(ro_ch), .ro_data(ro_data), .ro_frame(ro_frame)
  );

  always #5 clk_master = ~clk_master;

  task automatic step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0; en = 1'b0; latch_mode = 1'b0; ch_mask = 4'hf; ch_data = '0;
    step();
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    #2 rstb = 1'b0;
    #1;
    n_cmp++; if (gray_count !== 6'd0) begin n_fail++; $display("FAIL reset_gray got=%b exp=000000", gray_count); end
    n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ro_valid); end
    n_cmp++; if (ro_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got=%0d exp=0", ro_ch); end
    n_cmp++; if (ro_data !== 2'd0) begin n_fail++; $display("FAIL reset_data got=%b exp=00", ro_data); end
    n_cmp++; if (ro_frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got=%b exp=0", ro_frame); end
    step();
    rstb = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1; ch_mask = 4'b1111; ch_data = 8'b11_10_01_00;
    for (int b = 0; b < 32; b++) begin
      step();
      if (b < 8) begin
        n_cmp++; if (ro_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid bin=%0d got=%b exp=1", b, ro_valid); end
        n_cmp++; if (ro_ch !== exp_seq[b]) begin n_fail++; $display("FAIL basic_ch bin=%0d got=%0d exp=%0d", b, ro_ch, exp_seq[b]); end
        n_cmp++; if (ro_data !== exp_seq[b]) begin n_fail++; $display("FAIL basic_data bin=%0d got=%b exp=%b", b, ro_data, exp_seq[b]); end
      end
      if (b == 4) begin
        n_cmp++; if (gray_count !== 6'b000111) begin n_fail++; $display("FAIL basic_gray5 got=%b exp=000111", gray_count); end
      end
      if (b == 15 || b == 31) begin
        n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL basic_unmapped bin=%0d got=%b exp=0", b, ro_valid); end
      end
    end
  endtask

  task automatic test_wrap();
    int frames;
    frames = 0;
    do_reset();
    en = 1'b1; ch_mask = 4'b1111; ch_data = 8'b11_10_01_00;
    for (int b = 0; b < 64; b++) begin
      step();
      if (ro_frame === 1'b1) frames++;
      if (b == 63) begin
        n_cmp++; if (ro_frame !== 1'b1) begin n_fail++; $display("FAIL wrap_frame got=%b exp=1", ro_frame); end
        n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid got=%b exp=0", ro_valid); end
        n_cmp++; if (gray_count !== 6'd0) begin n_fail++; $display("FAIL wrap_gray got=%b exp=000000", gray_count); end
      end
    end
    n_cmp++; if (frames !== 1) begin n_fail++; $display("FAIL wrap_frame_count got=%0d exp=1", frames); end
  endtask

  task automatic test_sticky();
    do_reset();
    en = 1'b1; latch_mode = 1'b1; ch_mask = 4'b1111;
    for (int b = 0; b < 24; b++) begin
      ch_data = (b == 1) ? 8'b01_00_00_00 : 8'h00;
      step();
      if (b == 7 || b == 23) begin
        n_cmp++; if (ro_valid !== 1'b1) begin n_fail++; $display("FAIL sticky_valid bin=%0d got=%b exp=1", b, ro_valid); end
        n_cmp++; if (ro_ch !== 2'd3) begin n_fail++; $display("FAIL sticky_ch bin=%0d got=%0d exp=3", b, ro_ch); end
        n_cmp++; if (ro_data !== ((b == 7) ? 2'b01 : 2'b00)) begin
          n_fail++; $display("FAIL sticky_data bin=%0d got=%b exp=%b", b, ro_data, (b == 7) ? 2'b01 : 2'b00);
        end
      end
      if (b == 15) begin
        n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL sticky_bin15 got=%b exp=0", ro_valid); end
      end
    end
    ch_data = '0;
    do_reset();
    en = 1'b1; latch_mode = 1'b0; ch_mask = 4'b1111;
    for (int b = 0; b < 8; b++) begin
      ch_data = (b == 1) ? 8'b01_00_00_00 : 8'h00;
      step();
    end
    n_cmp++; if (ro_ch !== 2'd3) begin n_fail++; $display("FAIL nosticky_ch got=%0d exp=3", ro_ch); end
    n_cmp++; if (ro_data !== 2'b00) begin n_fail++; $display("FAIL nosticky_data got=%b exp=00", ro_data); end
  endtask

  task automatic test_mask();
    do_reset();
    en = 1'b1; ch_mask = 4'b1101; ch_data = 8'b11_10_01_00;
    for (int b = 0; b < 16; b++) begin
      step();
      if (b == 1 || b == 5 || b == 9 || b == 13) begin
        n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL mask_valid bin=%0d got=%b exp=0", b, ro_valid); end
        n_cmp++; if (ro_data !== 2'b00) begin n_fail++; $display("FAIL mask_data bin=%0d got=%b exp=00", b, ro_data); end
      end
      if (b == 0 || b == 3 || b == 7) begin
        n_cmp++; if (ro_valid !== 1'b1) begin n_fail++; $display("FAIL mask_keep_valid bin=%0d got=%b exp=1", b, ro_valid); end
        n_cmp++; if (ro_ch !== exp_seq[b]) begin n_fail++; $display("FAIL mask_keep_ch bin=%0d got=%0d exp=%0d", b, ro_ch, exp_seq[b]); end
        n_cmp++; if (ro_data !== exp_seq[b]) begin n_fail++; $display("FAIL mask_keep_data bin=%0d got=%b exp=%b", b, ro_data, exp_seq[b]); end
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    en = 1'b1; latch_mode = 1'b1; ch_mask = 4'b1111; ch_data = '0;
    step(); step(); step();
    en = 1'b0;
    for (int g = 0; g < 10; g++) begin
      ch_data = (g == 4) ? 8'b00_10_00_00 : 8'h00;
      step();
      n_cmp++; if (gray_count !== 6'b000010) begin n_fail++; $display("FAIL gap_gray cyc=%0d got=%b exp=000010", g, gray_count); end
      n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid cyc=%0d got=%b exp=0", g, ro_valid); end
    end
    ch_data = '0; en = 1'b1;
    step();
    n_cmp++; if (ro_valid !== 1'b1) begin n_fail++; $display("FAIL gap_post_valid got=%b exp=1", ro_valid); end
    n_cmp++; if (ro_ch !== 2'd2) begin n_fail++; $display("FAIL gap_post_ch got=%0d exp=2", ro_ch); end
    n_cmp++; if (ro_data !== 2'b10) begin n_fail++; $display("FAIL gap_post_data got=%b exp=10", ro_data); end
  endtask

  task automatic test_midreset();
    do_reset();
    en = 1'b1; latch_mode = 1'b1; ch_mask = 4'b1111;
    for (int b = 0; b < 37; b++) begin
      ch_data = (b == 36) ? 8'b01_00_00_11 : 8'h00;
      step();
    end
    ch_data = '0;
    n_cmp++; if (ro_data !== 2'b11) begin n_fail++; $display("FAIL midrst_pre_data got=%b exp=11", ro_data); end
    #2 rstb = 1'b0;
    #1;
    n_cmp++; if (gray_count !== 6'd0) begin n_fail++; $display("FAIL midrst_gray got=%b exp=000000", gray_count); end
    n_cmp++; if (ro_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", ro_valid); end
    n_cmp++; if (ro_ch !== 2'd0) begin n_fail++; $display("FAIL midrst_ch got=%0d exp=0", ro_ch); end
    n_cmp++; if (ro_data !== 2'd0) begin n_fail++; $display("FAIL midrst_data got=%b exp=00", ro_data); end
    n_cmp++; if (ro_frame !== 1'b0) begin n_fail++; $display("FAIL midrst_frame got=%b exp=0", ro_frame); end
    step();
    rstb = 1'b1;
    for (int b = 0; b < 8; b++) begin
      step();
      n_cmp++; if (ro_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_seq_valid bin=%0d got=%b exp=1", b, ro_valid); end
      n_cmp++; if (ro_ch !== exp_seq[b]) begin n_fail++; $display("FAIL midrst_seq_ch bin=%0d got=%0d exp=%0d", b, ro_ch, exp_seq[b]); end
      n_cmp++; if (ro_data !== 2'b00) begin n_fail++; $display("FAIL midrst_seq_data bin=%0d got=%b exp=00", b, ro_data); end
    end
  endtask

  initial begin
    rstb = 1'b1; en = 1'b0; latch_mode = 1'b0; ch_mask = '0; ch_data = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_sticky();
    test_mask();
    test_gap();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
